nfc_flash_target: RTL and testbench



---
 rtl/nfc_flash_target_if.sv | 25 ++
 rtl/nfc_flash_target.sv | 266 ++++++++++++++++++++++++++
 tb/tb_nfc_flash_target.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_flash_target_if.sv
// NAND flash bus between the NFC host (master) and the flash target (slave).
// Carries the CE#/CLE/ALE/WE#/RE# strobes, the split DQ bus and R/B#.
interface nfc_flash_target_if #(
    parameter int DAT_WID = 8
);
    logic               nf_ceb;
    logic               nf_cle;
    logic               nf_ale;
    logic               nf_web;
    logic               nf_reb;
    logic [DAT_WID-1:0] nf_dq_in;
    logic [DAT_WID-1:0] nf_dq_out;
    logic               nf_dq_oe;
    logic               nf_rb;

    modport master (
        output nf_ceb, nf_cle, nf_ale, nf_web, nf_reb, nf_dq_in,
        input  nf_dq_out, nf_dq_oe, nf_rb
    );

    modport slave (
        input  nf_ceb, nf_cle, nf_ale, nf_web, nf_reb, nf_dq_in,
        output nf_dq_out, nf_dq_oe, nf_rb
    );
endinterface

// File: rtl/nfc_flash_target.sv
// NAND flash target model: decodes command/address/data cycles on the bus,
// holds one page buffer and returns page data, status and ID bytes with R/B#.
module nfc_flash_target #(
    parameter int          DAT_WID  = 8,
    parameter int          PAGE_AW  = 6,
    parameter int          COL_CYC  = 2,
    parameter int          ROW_CYC  = 3,
    parameter int          BUSY_RD  = 32,
    parameter int          BUSY_PG  = 64,
    parameter int          BUSY_RST = 16,
    parameter logic [31:0] ID_CODE  = 32'hECD3_5195
) (
    input  logic              clk,
    input  logic              rst_n,
    nfc_flash_target_if.slave nf,
    output logic [31:0]       tgt_row_addr,
    output logic [15:0]       tgt_col_addr,
    output logic [7:0]        tgt_last_cmd
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DIN  = 3'd2;
    localparam logic [2:0] ST_BUSY = 3'd3;
    localparam logic [2:0] ST_DOUT = 3'd4;
    localparam logic [2:0] ST_STAT = 3'd5;
    localparam logic [2:0] ST_ID   = 3'd6;

    localparam logic [1:0] AM_READ = 2'd0;
    localparam logic [1:0] AM_PROG = 2'd1;
    localparam logic [1:0] AM_ID   = 2'd2;

    localparam int         BUSY_W   = 16;
    localparam logic [3:0] ADDR_TOT = 4'(COL_CYC + ROW_CYC);
    localparam logic [3:0] COL_TOT  = 4'(COL_CYC);

    logic               ceb_p1;
    logic               cle_p1, cle_p2;
    logic               ale_p1, ale_p2;
    logic               web_p1, web_p2;
    logic               reb_p1, reb_p2;
    logic [DAT_WID-1:0] dq_p1, dq_p2;

    logic [DAT_WID-1:0] page_mem [2**PAGE_AW];

    logic [2:0]        state, ret_state, busy_next;
    logic [1:0]        amode;
    logic [3:0]        addr_cnt;
    logic              busy_act;
    logic [BUSY_W-1:0] busy_cnt;
    logic [15:0]       col_q;
    logic [31:0]       row_q;
    logic [7:0]        last_cmd;
    logic [1:0]        id_idx;
    logic [DAT_WID-1:0] dq_out_q;
    logic              oe_q;

    logic       we_rise, re_fall, re_rise;
    logic       cmd_ev, addr_ev, data_ev;
    logic [7:0] dq8;
    logic       busy_done;
    logic [2:0] state_now, dec_state;
    logic [3:0] row_sel;

    function automatic logic [15:0] col_wrap(input logic [15:0] c);
        logic [PAGE_AW-1:0] low;
        low = c[PAGE_AW-1:0] + 1'b1;
        return 16'(low);
    endfunction

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return ID_CODE[7:0];
            2'd1:    return ID_CODE[15:8];
            2'd2:    return ID_CODE[23:16];
            default: return ID_CODE[31:24];
        endcase
    endfunction

    function automatic logic [DAT_WID-1:0] stat_byte(input logic busy);
        return DAT_WID'(busy ? 8'h80 : 8'hC0);
    endfunction

    // Stage p1/p2: double-register the asynchronous bus for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ceb_p1 <= 1'b1;
            cle_p1 <= 1'b0;
            cle_p2 <= 1'b0;
            ale_p1 <= 1'b0;
            ale_p2 <= 1'b0;
            web_p1 <= 1'b1;
            web_p2 <= 1'b1;
            reb_p1 <= 1'b1;
            reb_p2 <= 1'b1;
        end else begin
            ceb_p1 <= nf.nf_ceb;
            cle_p1 <= nf.nf_cle;
            cle_p2 <= cle_p1;
            ale_p1 <= nf.nf_ale;
            ale_p2 <= ale_p1;
            web_p1 <= nf.nf_web;
            web_p2 <= web_p1;
            reb_p1 <= nf.nf_reb;
            reb_p2 <= reb_p1;
        end
    end

    always_ff @(posedge clk) begin
        dq_p1 <= nf.nf_dq_in;
        dq_p2 <= dq_p1;
    end

    assign we_rise = !ceb_p1 && web_p1 && !web_p2;
    assign re_fall = !ceb_p1 && !reb_p1 && reb_p2;
    assign re_rise = !ceb_p1 && reb_p1 && !reb_p2;
    assign cmd_ev  = we_rise && cle_p2 && !ale_p2;
    assign addr_ev = we_rise && ale_p2 && !cle_p2;
    assign data_ev = we_rise && !cle_p2 && !ale_p2;
    assign dq8     = dq_p2[7:0];

    assign busy_done = busy_act && (busy_cnt == '0);
    assign state_now = (busy_done && state == ST_BUSY) ? busy_next : state;
    // A command issued from STAT is decoded as if STAT had never been entered
    assign dec_state = (state == ST_STAT) ? ret_state : state;
    assign row_sel   = addr_cnt - COL_TOT;

    always_ff @(posedge clk) begin
        if (data_ev && state == ST_DIN)
            page_mem[col_q[PAGE_AW-1:0]] <= dq_p2;
    end

    // Stage p3: command/address/data decode and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            busy_next <= ST_IDLE;
            amode     <= AM_READ;
            addr_cnt  <= '0;
            busy_act  <= 1'b0;
            busy_cnt  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            last_cmd  <= 8'h00;
            id_idx    <= '0;
            dq_out_q  <= '0;
            oe_q      <= 1'b0;
        end else begin
            if (busy_act) begin
                if (busy_cnt == '0) begin
                    busy_act <= 1'b0;
                    if (state == ST_BUSY)
                        state <= busy_next;
                    else if (ret_state == ST_BUSY)
                        ret_state <= busy_next;
                end else begin
                    busy_cnt <= busy_cnt - 1'b1;
                end
            end

            if (cmd_ev) begin
                oe_q <= 1'b0;
                if (dq8 == 8'hFF) begin
                    state     <= ST_BUSY;
                    busy_next <= ST_IDLE;
                    busy_act  <= 1'b1;
                    busy_cnt  <= BUSY_W'(BUSY_RST - 1);
                    last_cmd  <= dq8;
                end else if (dq8 == 8'h70) begin
                    if (state != ST_STAT)
                        ret_state <= state_now;
                    state    <= ST_STAT;
                    last_cmd <= dq8;
                end else if (!busy_act) begin
                    case (dq8)
                        8'h00, 8'h80: begin
                            state    <= ST_ADDR;
                            amode    <= (dq8 == 8'h80) ? AM_PROG : AM_READ;
                            addr_cnt <= '0;
                            col_q    <= '0;
                            last_cmd <= dq8;
                        end
                        8'h90: begin
                            state    <= ST_ADDR;
                            amode    <= AM_ID;
                            last_cmd <= dq8;
                        end
                        8'h30: begin
                            if (dec_state == ST_ADDR && amode == AM_READ && addr_cnt == ADDR_TOT) begin
                                state     <= ST_BUSY;
                                busy_next <= ST_DOUT;
                                busy_act  <= 1'b1;
                                busy_cnt  <= BUSY_W'(BUSY_RD - 1);
                                last_cmd  <= dq8;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        8'h10: begin
                            if (dec_state == ST_DIN) begin
                                state     <= ST_BUSY;
                                busy_next <= ST_IDLE;
                                busy_act  <= 1'b1;
                                busy_cnt  <= BUSY_W'(BUSY_PG - 1);
                                last_cmd  <= dq8;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (addr_ev && state == ST_ADDR) begin
                if (amode == AM_ID) begin
                    state  <= ST_ID;
                    id_idx <= '0;
                end else if (addr_cnt < ADDR_TOT) begin
                    if (addr_cnt < COL_TOT)
                        col_q <= col_q | (16'(dq8) << {addr_cnt, 3'b000});
                    else if (row_sel == '0)
                        row_q <= 32'(dq8);
                    else
                        row_q <= row_q | (32'(dq8) << {row_sel, 3'b000});
                    addr_cnt <= addr_cnt + 1'b1;
                    if (amode == AM_PROG && addr_cnt + 1'b1 == ADDR_TOT)
                        state <= ST_DIN;
                end
            end else if (data_ev && state == ST_DIN) begin
                col_q <= col_wrap(col_q);
            end

            if (re_fall) begin
                case (state)
                    ST_DOUT: begin
                        dq_out_q <= page_mem[col_q[PAGE_AW-1:0]];
                        oe_q     <= 1'b1;
                    end
                    ST_STAT: begin
                        dq_out_q <= stat_byte(busy_act);
                        oe_q     <= 1'b1;
                    end
                    ST_ID: begin
                        dq_out_q <= DAT_WID'(id_byte(id_idx));
                        id_idx   <= id_idx + 1'b1;
                        oe_q     <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (re_rise) begin
                oe_q <= 1'b0;
                if (state == ST_DOUT)
                    col_q <= col_wrap(col_q);
            end
        end
    end

    assign nf.nf_dq_out = dq_out_q;
    assign nf.nf_dq_oe  = oe_q && !ceb_p1 && !reb_p1;
    assign nf.nf_rb     = !busy_act;

    assign tgt_row_addr = row_q;
    assign tgt_col_addr = col_q;
    assign tgt_last_cmd = last_cmd;

endmodule

// File: tb/tb_nfc_flash_target.sv
// Scoreboard bench for nfc_flash_target: drives bus cycles, predicts page,
// status, ID bytes and busy lengths from a page-level model.
module tb_nfc_flash_target;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    nfc_flash_target_if #(.DAT_WID(8)) bus ();

    logic [31:0] row_addr;
    logic [15:0] col_addr;
    logic [7:0]  last_cmd;

    nfc_flash_target dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nf           (bus),
        .tgt_row_addr (row_addr),
        .tgt_col_addr (col_addr),
        .tgt_last_cmd (last_cmd)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] page [64];
    logic [7:0] pdata [$];
    logic [7:0] exp_q [$];
    int         busy_q [$];
    int         mcol = 0;
    logic [31:0] id_val = 32'hECD3_5195;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: output bytes on each oe rise, busy-run lengths on each rb rise
    logic oe_prev = 1'b0;
    int   busy_run = 0;
    always @(negedge clk) begin
        if (bus.nf_dq_oe && !oe_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h expected no output", bus.nf_dq_out);
            end else begin
                chk("dq_out", 32'(bus.nf_dq_out), 32'(exp_q.pop_front()));
            end
        end
        oe_prev = bus.nf_dq_oe;
        if (!bus.nf_rb) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (busy_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy: got %0d cycles expected none", busy_run);
            end else begin
                chk("busy_len", 32'(busy_run), 32'(busy_q.pop_front()));
            end
            busy_run = 0;
        end
    end

    task automatic wr_cycle(input logic c, input logic a, input logic [7:0] d);
        @(negedge clk);
        bus.nf_cle   = c;
        bus.nf_ale   = a;
        bus.nf_dq_in = d;
        bus.nf_web   = 1'b0;
        repeat (3) @(negedge clk);
        bus.nf_web = 1'b1;
        repeat (3) @(negedge clk);
        bus.nf_cle = 1'b0;
        bus.nf_ale = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] c);
        wr_cycle(1'b1, 1'b0, c);
    endtask

    task automatic send_addr(input int col, input int row);
        for (int i = 0; i < 2; i++) wr_cycle(1'b0, 1'b1, 8'(col >> (8 * i)));
        for (int i = 0; i < 3; i++) wr_cycle(1'b0, 1'b1, 8'(row >> (8 * i)));
    endtask

    task automatic re_pulse();
        @(negedge clk);
        bus.nf_reb = 1'b0;
        repeat (4) @(negedge clk);
        bus.nf_reb = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.nf_rb && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.nf_rb) begin
            checks++;
            errors++;
            $display("FAIL rb_timeout: got rb=0 after %0d cycles expected rb=1", n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Program setup: 0x80, address, then every byte queued in pdata
    task automatic prog_load(input int col, input int row);
        int c;
        c = col;
        cmd(8'h80);
        send_addr(col, row);
        while (pdata.size() > 0) begin
            logic [7:0] b;
            b = pdata.pop_front();
            wr_cycle(1'b0, 1'b0, b);
            page[c % 64] = b;
            c++;
        end
    endtask

    task automatic prog_commit();
        cmd(8'h10);
        busy_q.push_back(64);
        wait_ready();
    endtask

    task automatic read_back(input int col, input int row, input int n);
        cmd(8'h00);
        send_addr(col, row);
        cmd(8'h30);
        busy_q.push_back(32);
        wait_ready();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(page[(col + i) % 64]);
            re_pulse();
        end
        mcol = (col + n) % 64;
        chk("row_addr", row_addr, 32'(row));
        chk("col_addr", 32'(col_addr), 32'(mcol));
        chk("last_cmd_rd", 32'(last_cmd), 32'h30);
    endtask

    initial begin
        bus.nf_ceb   = 1'b0;
        bus.nf_cle   = 1'b0;
        bus.nf_ale   = 1'b0;
        bus.nf_web   = 1'b1;
        bus.nf_reb   = 1'b1;
        bus.nf_dq_in = 8'h00;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oe", 32'(bus.nf_dq_oe), 32'h0);
        chk("rst_rb", 32'(bus.nf_rb), 32'h1);
        chk("rst_dq", 32'(bus.nf_dq_out), 32'h0);
        chk("rst_row", row_addr, 32'h0);
        chk("rst_col", 32'(col_addr), 32'h0);
        chk("rst_cmd", 32'(last_cmd), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Program/read loopback with status polled during and after busy
        pdata = '{8'h11, 8'h22, 8'h33};
        prog_load(0, 1);
        cmd(8'h10);
        busy_q.push_back(64);
        cmd(8'h70);
        exp_q.push_back(8'h80);
        re_pulse();
        wait_ready();
        exp_q.push_back(8'hC0);
        re_pulse();
        read_back(0, 1, 3);

        // Fill the rest of the page with random bytes
        for (int i = 3; i < 64; i++) pdata.push_back(8'($urandom));
        prog_load(3, 2);
        prog_commit();

        // Column wrap
        pdata = '{8'hA5, 8'h5A};
        prog_load(63, 7);
        prog_commit();
        chk("wrap_b63", 32'(page[63]), 32'hA5);
        read_back(63, 7, 2);

        // ID read wraps after four bytes
        cmd(8'h90);
        wr_cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(id_val >> (8 * (i % 4))));
            re_pulse();
        end

        // Randomized program / read traffic
        for (int it = 0; it < 6; it++) begin
            int c, n, r;
            if ($urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, 63);
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) pdata.push_back(8'($urandom));
                prog_load(c, $urandom_range(0, 255));
                prog_commit();
            end
            c = $urandom_range(0, 63);
            n = $urandom_range(1, 4);
            r = int'($urandom_range(0, 24'hFFFFFF));
            read_back(c, r, n);
        end

        // Reset command aborts an ongoing program
        pdata = '{8'h3C, 8'hC3};
        prog_load(10, 5);
        cmd(8'h10);
        busy_q.push_back(26);
        repeat (3) @(negedge clk);
        cmd(8'hFF);
        wait_ready();
        chk("abort_cmd", 32'(last_cmd), 32'hFF);
        chk("abort_col", 32'(col_addr), 32'd12);
        wr_cycle(1'b0, 1'b0, 8'hEE);
        chk("abort_data_col", 32'(col_addr), 32'd12);
        read_back(12, 5, 1);

        // CE# high: bus activity must have no effect
        @(negedge clk);
        bus.nf_ceb = 1'b1;
        repeat (2) @(negedge clk);
        cmd(8'h80);
        wr_cycle(1'b0, 1'b0, 8'h77);
        re_pulse();
        chk("ce_cmd", 32'(last_cmd), 32'h30);
        chk("ce_col", 32'(col_addr), 32'(mcol));
        bus.nf_ceb = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(page[mcol]);
        re_pulse();
        mcol = (mcol + 1) % 64;

        // Asynchronous reset while data is being driven
        exp_q.push_back(page[mcol]);
        @(negedge clk);
        bus.nf_reb = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_oe", 32'(bus.nf_dq_oe), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 32'(bus.nf_dq_oe), 32'h0);
        chk("arst_rb", 32'(bus.nf_rb), 32'h1);
        chk("arst_cmd", 32'(last_cmd), 32'h0);
        chk("arst_col", 32'(col_addr), 32'h0);
        @(negedge clk);
        bus.nf_reb = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("exp_left", 32'(exp_q.size()), 32'h0);
        chk("busy_left", 32'(busy_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
